// File: rtl/alu_pkg.sv
// Shared types for the pipelined arithmetic unit: opcode enum, status bit indices, status word.
// Optional build macro ALU_SATURATE_EN is consumed by alu_core_comb.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 2;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_SUB  = 2'b00,
        ALU_COMP = 2'b01,
        ALU_SUM  = 2'b10,
        ALU_CONV = 2'b11
    } alu_op_e;

    localparam int unsigned ST_OVF  = 0;
    localparam int unsigned ST_ZERO = 1;
    localparam int unsigned ST_NEG  = 2;
    localparam int unsigned ST_PAR  = 3;

    // Field order matches the ST_* indices (par is bit 3, ovf is bit 0).
    typedef struct packed {
        logic par;
        logic neg;
        logic zero;
        logic ovf;
    } status_t;

endpackage

// File: rtl/alu_core_comb.sv
// Combinational datapath: op/A/B -> result and status word.
// Define ALU_SATURATE_EN to clamp overflowing SUB/SUM results instead of wrapping.
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int unsigned M = 8
) (
    input  alu_op_e      op_i,
    input  logic [M-1:0] a_i,
    input  logic [M-1:0] b_i,
    output logic [M-1:0] result_o,
    output logic [3:0]   status_o
);

`ifdef ALU_SATURATE_EN
    localparam logic [M-1:0] MaxPos = {1'b0, {(M-1){1'b1}}};
`endif
    localparam logic [M-1:0] MinNeg = {1'b1, {(M-1){1'b0}}};

    logic [M+1:0] sub_full;
    logic [M:0]   sum_full;
    logic [M-1:0] neg_a;
    logic         sub_ovf;
    logic         sum_ovf;
    logic         a_lt_b;
    logic         ovf;

    always_comb begin
        // A - 2B at M+2 bits; {b, 0} is 2B sign-extended by one bit.
        sub_full = {{2{a_i[M-1]}}, a_i} - {b_i[M-1], b_i, 1'b0};
        sum_full = {a_i[M-1], a_i} + {b_i[M-1], b_i};
        neg_a    = '0 - a_i;
        sub_ovf  = !((sub_full[M+1:M-1] == 3'b000) || (sub_full[M+1:M-1] == 3'b111));
        sum_ovf  = sum_full[M] ^ sum_full[M-1];
        a_lt_b   = $signed(a_i) < $signed(b_i);
    end

    always_comb begin
        result_o = '0;
        ovf      = 1'b0;
        unique case (op_i)
            ALU_SUB: begin
                result_o = sub_full[M-1:0];
                ovf      = sub_ovf;
`ifdef ALU_SATURATE_EN
                if (sub_ovf) result_o = sub_full[M+1] ? MinNeg : MaxPos;
`endif
            end
            ALU_COMP: begin
                result_o = {{(M-1){1'b0}}, a_lt_b};
            end
            ALU_SUM: begin
                result_o = sum_full[M-1:0];
                ovf      = sum_ovf;
`ifdef ALU_SATURATE_EN
                if (sum_ovf) result_o = sum_full[M] ? MinNeg : MaxPos;
`endif
            end
            ALU_CONV: begin
                if (a_i == MinNeg) begin
                    // Most-negative value has no magnitude in M-1 bits; pass it through.
                    result_o = a_i;
                    ovf      = 1'b1;
                end else if (a_i[M-1]) begin
                    result_o = {1'b1, neg_a[M-2:0]};
                end else begin
                    result_o = a_i;
                end
            end
            default: begin
                result_o = '0;
                ovf      = 1'b0;
            end
        endcase
    end

    always_comb begin
        status_o          = '0;
        status_o[ST_OVF]  = ovf;
        status_o[ST_ZERO] = (result_o == '0);
        status_o[ST_NEG]  = result_o[M-1];
        status_o[ST_PAR]  = ~(^result_o);
    end

endmodule

// File: rtl/sync_arith_unit_n.sv
// Two-stage valid/ready pipelined arithmetic unit (SUB, COMP, SUM, CONV) with status word.
// Build macro ALU_SATURATE_EN selects saturating SUB/SUM (see alu_core_comb).
module sync_arith_unit_n
    import alu_pkg::*;
#(
    parameter int unsigned M = 8,
    parameter int unsigned N = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_op,
    input  logic [M-1:0] i_arg_A,
    input  logic [M-1:0] i_arg_B,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);

    if (M < 4 || M > 32) begin : g_bad_width
        $error("sync_arith_unit_n: M must lie in 4..32");
    end
    if (N != ALU_OP_W) begin : g_bad_op_width
        $error("sync_arith_unit_n: N must equal 2");
    end

    logic         s1_valid_q;
    alu_op_e      op_q;
    logic [M-1:0] a_q;
    logic [M-1:0] b_q;

    logic         out_valid_q;
    logic [M-1:0] result_q;
    status_t      status_q;

    logic         stage2_load;
    logic         stage1_load;
    logic [M-1:0] core_result;
    logic [3:0]   core_status;

    // Handshake depends only on i_ready and register state, never on i_valid.
    always_comb begin
        stage2_load = !out_valid_q || i_ready;
        stage1_load = !s1_valid_q || stage2_load;
        o_ready     = stage1_load;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_valid_q <= 1'b0;
            op_q       <= ALU_SUB;
            a_q        <= '0;
            b_q        <= '0;
        end else if (stage1_load) begin
            s1_valid_q <= i_valid;
            if (i_valid) begin
                op_q <= alu_op_e'(i_op);
                a_q  <= i_arg_A;
                b_q  <= i_arg_B;
            end
        end
    end

    alu_core_comb #(
        .M (M)
    ) u_core (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (core_result),
        .status_o (core_status)
    );

    // Output registers hold their value across bubbles and stalls.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            status_q    <= '0;
        end else if (stage2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= core_result;
                status_q <= status_t'(core_status);
            end
        end
    end

    always_comb begin
        o_valid  = out_valid_q;
        o_result = result_q;
        o_status = status_q;
    end

endmodule
